// File: rtl/disp_scan.sv
// disp_scan: converts a 10-bit balance and a 10-bit remaining time to 4-digit
// BCD (serial double-dabble, 10 clocks) and scans both results onto two
// multiplexed 4-digit displays with leading-zero blanking.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   load       single-cycle request to capture bal/time_left (ignored while busy)
//   bal        balance, unsigned binary      -> right display group
//   time_left  remaining time, unsigned bin  -> left display group
//   busy       high while a conversion is running
//   ena_l/r    one-hot digit enables, both groups scan in lockstep
//   l_light    BCD of enabled time_left digit, 4'hF = blank
//   r_light    BCD of enabled bal digit,       4'hF = blank
module disp_scan #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [9:0] bal,
    input  logic [9:0] time_left,
    output logic       busy,
    output logic [3:0] ena_l,
    output logic [3:0] ena_r,
    output logic [3:0] l_light,
    output logic [3:0] r_light
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);

    typedef enum logic {IDLE, CONV} state_e;

    state_e state_q, state_d;

    logic [9:0]    bin_b_q, bin_b_d, bin_t_q, bin_t_d;
    logic [15:0]   bcd_b_q, bcd_b_d, bcd_t_q, bcd_t_d;
    logic [3:0]    step_q, step_d;
    logic [15:0]   disp_b_q, disp_b_d, disp_t_q, disp_t_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    ena_q, ena_d;
    logic [3:0]    l_q, l_d, r_q, r_d;
    logic [15:0]   adj_b, adj_t;

    // Double-dabble correction: add 3 to every nibble >= 5 before shifting.
    function automatic logic [15:0] dd_adj(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int unsigned n = 0; n < 4; n++) begin
            if (v[4*n +: 4] >= 4'd5) r[4*n +: 4] = v[4*n +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Digit select with leading-zero blanking: blank when this nibble and all
    // higher ones are zero, except the ones digit.
    function automatic logic [3:0] pick(input logic [15:0] d, input logic [1:0] idx);
        logic [15:0] sh;
        sh = d >> {idx, 2'b00};
        if (idx != 2'd0 && sh == '0) return 4'hF;
        return sh[3:0];
    endfunction

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (load)           state_d = CONV;
            CONV: if (step_q == 4'd9) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == CONV);
    end

    // Conversion datapath and scan logic
    always_comb begin
        bin_b_d  = bin_b_q;
        bin_t_d  = bin_t_q;
        bcd_b_d  = bcd_b_q;
        bcd_t_d  = bcd_t_q;
        step_d   = step_q;
        disp_b_d = disp_b_q;
        disp_t_d = disp_t_q;
        adj_b    = dd_adj(bcd_b_q);
        adj_t    = dd_adj(bcd_t_q);

        if (state_q == IDLE && load) begin
            bin_b_d = bal;
            bin_t_d = time_left;
            bcd_b_d = '0;
            bcd_t_d = '0;
            step_d  = '0;
        end else if (state_q == CONV) begin
            bcd_b_d = {adj_b[14:0], bin_b_q[9]};
            bcd_t_d = {adj_t[14:0], bin_t_q[9]};
            bin_b_d = {bin_b_q[8:0], 1'b0};
            bin_t_d = {bin_t_q[8:0], 1'b0};
            step_d  = step_q + 4'd1;
            if (step_q == 4'd9) begin
                disp_b_d = bcd_b_d;
                disp_t_d = bcd_t_d;
            end
        end

        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_TC) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end

        // Output registers are fed from next-state values so the enable and
        // its digit (including a freshly converted one) change on one edge.
        ena_d = 4'b0001 << idx_d;
        l_d   = pick(disp_t_d, idx_d);
        r_d   = pick(disp_b_d, idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_b_q  <= '0;
            bin_t_q  <= '0;
            bcd_b_q  <= '0;
            bcd_t_q  <= '0;
            step_q   <= '0;
            disp_b_q <= '0;
            disp_t_q <= '0;
            presc_q  <= '0;
            idx_q    <= '0;
            ena_q    <= 4'b0001;
            l_q      <= '0;
            r_q      <= '0;
        end else begin
            bin_b_q  <= bin_b_d;
            bin_t_q  <= bin_t_d;
            bcd_b_q  <= bcd_b_d;
            bcd_t_q  <= bcd_t_d;
            step_q   <= step_d;
            disp_b_q <= disp_b_d;
            disp_t_q <= disp_t_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            ena_q    <= ena_d;
            l_q      <= l_d;
            r_q      <= r_d;
        end
    end

    assign ena_l   = ena_q;
    assign ena_r   = ena_q;
    assign l_light = l_q;
    assign r_light = r_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with SCAN_DIV=4: reset state, idle scan,
// conversions with hand-picked values, load-while-busy, reset mid-conversion,
// and a sweep of every input value against a decimal reference.
module tb_disp_scan;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [9:0] bal = '0;
    logic [9:0] time_left = '0;
    logic       busy;
    logic [3:0] ena_l, ena_r, l_light, r_light;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned tb_cyc;
    int unsigned shown_b = 0;
    int unsigned shown_t = 0;

    disp_scan #(.SCAN_DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .bal       (bal),
        .time_left (time_left),
        .busy      (busy),
        .ena_l     (ena_l),
        .ena_r     (ena_r),
        .l_light   (l_light),
        .r_light   (r_light)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; the expected digit index follows from it.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Decimal reference: digit k of v, or 4'hF when blanked.
    function automatic logic [3:0] exp_light(input int unsigned v, input int unsigned k);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < k; i++) p = p * 10;
        if (k != 0 && v < p) return 4'hF;
        return 4'((v / p) % 10);
    endfunction

    task automatic check_out(input string tag);
        int unsigned idx;
        logic [3:0]  e;
        idx = (tb_cyc / DIV) % 4;
        e   = 4'(1 << idx);
        check({tag, ".ena_l"}, 16'(ena_l), 16'(e));
        check({tag, ".ena_r"}, 16'(ena_r), 16'(e));
        check({tag, ".l_light"}, 16'(l_light), 16'(exp_light(shown_t, idx)));
        check({tag, ".r_light"}, 16'(r_light), 16'(exp_light(shown_b, idx)));
    endtask

    // Called at a negedge with the DUT idle. Optionally re-asserts load with
    // other data three cycles into the conversion.
    task automatic run_conv(input string tag, input int unsigned b, input int unsigned t,
                            input bit inject);
        bal = 10'(b);
        time_left = 10'(t);
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            check({tag, ".busy"}, 16'(busy), 16'd1);
            check_out({tag, ".old"});
            if (inject && k == 3) begin
                load = 1'b1;
                bal = 10'd512;
                time_left = 10'd7;
            end
            if (inject && k == 4) load = 1'b0;
            @(negedge clk);
        end
        check({tag, ".done"}, 16'(busy), 16'd0);
        shown_b = b;
        shown_t = t;
        for (int unsigned k = 0; k < 16; k++) begin
            check_out({tag, ".new"});
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst.busy", 16'(busy), 16'd0);
        check_out("rst");
        rst = 1'b0;
        for (int unsigned k = 0; k < 16; k++) begin
            check_out("idle");
            @(negedge clk);
        end

        run_conv("b1023_t45", 1023, 45, 1'b0);
        run_conv("b0_t1000", 0, 1000, 1'b0);
        run_conv("ignore", 300, 678, 1'b1);
        run_conv("b7", 7, 0, 1'b0);

        // Abort a conversion after five steps.
        bal = 10'd500;
        time_left = 10'd0;
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        for (int unsigned k = 0; k < 5; k++) begin
            check("abort.busy", 16'(busy), 16'd1);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        shown_b = 0;
        shown_t = 0;
        check("abort.rst_busy", 16'(busy), 16'd0);
        check_out("abort.rst");
        @(negedge clk);
        check_out("abort.hold");
        rst = 1'b0;
        run_conv("b99", 99, 0, 1'b0);

        for (int unsigned i = 0; i < 1024; i++) begin
            run_conv($sformatf("sweep%0d", i), i, 1023 - i, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
